// File: rtl/fsm_share_arbiter_pkg.sv
// rtl/fsm_share_arbiter_pkg.sv - shared state encodings and default widths for fsm_share_arbiter
package fsm_share_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_STATE_W = 3;
    localparam int DEF_Z_W     = 2;

    // Owner ids need at least one bit even for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm_share_arbiter_rr_pick.sv
// rtl/fsm_share_arbiter_rr_pick.sv - combinational round-robin picker (req, last_owner) -> one-hot, id, any
module rr_pick
    import fsm_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any_req
);

    logic [NUM_REQ-1:0] above;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] pool;

    // Prefer requesters above last_owner; fall back to the full set to wrap around.
    always_comb begin
        above = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            above[i] = (i > int'(last_owner));
        end
        masked = req & above;
        pool   = (masked != '0) ? masked : req;
        gnt    = '0;
        id     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                id     = ID_W'(i);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/fsm_share_arbiter.sv
// rtl/fsm_share_arbiter.sv - round-robin sequencer sharing one Moore FSM among NUM_REQ requesters
// Optional macro FSM_CLEAR_EN adds a one-cycle FSM clear state before every burst.
module fsm_share_arbiter
    import fsm_share_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int STATE_W  = DEF_STATE_W,
    parameter int Z_W      = DEF_Z_W,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_len,
    input  logic [NUM_REQ-1:0]       i_valid,
    input  logic [NUM_REQ-1:0]       i_x,
    input  logic [NUM_REQ-1:0]       i_y,
    output logic [NUM_REQ-1:0]       o_ready,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_fsm_x,
    output logic                     o_fsm_y,
    output logic                     o_fsm_en,
    output logic                     o_fsm_clr,
    input  logic [STATE_W-1:0]       i_fsm_sta,
    input  logic [Z_W-1:0]           i_fsm_z1,
    input  logic [Z_W-1:0]           i_fsm_z2,
    output logic                     o_rsp_valid,
    output logic [Z_W-1:0]           o_z1,
    output logic [Z_W-1:0]           o_z2,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [STATE_W-1:0]       o_last_sta
);

`ifdef FSM_CLEAR_EN
    localparam logic [1:0] ST_FIRST = ST_CLEAR;
`else
    localparam logic [1:0] ST_FIRST = ST_RUN;
`endif

    logic [1:0]         state;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    last_owner;
    logic [ID_W-1:0]    en_id;
    logic [LEN_W-1:0]   count;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic               owner_req;
    logic               accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (i_req),
        .last_owner (last_owner),
        .gnt        (pick_gnt),
        .id         (pick_id),
        .any_req    (pick_any)
    );

    // A dropped request aborts the burst, so ready is withheld in that cycle.
    assign owner_req   = i_req[owner];
    assign o_ready     = (state == ST_RUN && owner_req) ? gnt : '0;
    assign accept      = |(i_valid & o_ready);
    assign o_done      = (state == ST_DRAIN) ? gnt : '0;
    assign o_gnt       = gnt;
    assign o_z1        = o_rsp_valid ? i_fsm_z1 : '0;
    assign o_z2        = o_rsp_valid ? i_fsm_z2 : '0;

`ifdef FSM_CLEAR_EN
    assign o_fsm_clr = (state == ST_CLEAR);
`else
    assign o_fsm_clr = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            owner       <= '0;
            last_owner  <= ID_W'(NUM_REQ - 1);
            count       <= '0;
            en_id       <= '0;
            o_fsm_x     <= 1'b0;
            o_fsm_y     <= 1'b0;
            o_fsm_en    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= '0;
            o_last_sta  <= '0;
        end else begin
            o_fsm_en    <= accept;
            o_rsp_valid <= o_fsm_en;
            if (accept) begin
                o_fsm_x <= i_x[owner];
                o_fsm_y <= i_y[owner];
                en_id   <= owner;
            end
            if (o_fsm_en) begin
                o_rsp_id <= en_id;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_gnt;
                        owner <= pick_id;
                        count <= i_len[pick_id*LEN_W +: LEN_W];
                        state <= ST_FIRST;
                    end
                end
                ST_CLEAR: state <= ST_RUN;
                ST_RUN: begin
                    if (!owner_req) begin
                        state <= ST_DRAIN;
                    end else if (accept) begin
                        if (count == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    o_last_sta <= i_fsm_sta;
                    last_owner <= owner;
                    gnt        <= '0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
